imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction memory from a byte stream. Accepts a length header plus little-endian instruction bytes over a valid/ready handshake, assembles 32-bit words and issues single-cycle word writes on the instruction memory write port. Holds the core via `cpu_hold` while loading. It is the writer for the synchronous-read instruction memory, which indexes words with byte-address bits [ADDR_W+1:2].

## Interface

Parameters:
- `ADDR_W`, 8: word-address bits; depth = 2^ADDR_W words (256).
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written; must be word aligned.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle pulse that begins a load.
- `byte_valid` in 1: source has a byte.
- `byte_data` in 8: byte payload.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: one-cycle word write strobe.
- `mem_addr` out 32: byte address, word aligned.
- `mem_wdata` out 32: word to write.
- `cpu_hold` out 1: keep the core stalled or in reset.
- `busy` out 1: load in progress.
- `done` out 1: sticky flag for a successful load.
- `err` out 1: sticky flag for a failed load.

## Operation

- A byte transfers on a cycle with `byte_valid && byte_ready`.
- Stream format:
  - 2-byte word count N, LSB first.
  - Then 4N data bytes; each word is little-endian (first byte goes to [7:0]).
- States:
  - IDLE: `start` moves to LEN.
  - LEN: after 2 bytes, N=0 goes to DONE (or CSUM with the macro); N > 2^ADDR_W goes to ERR; otherwise goes to DATA.
  - DATA: after the 4th byte of a word, goes to WRITE.
  - WRITE: one cycle; increment the word index; index == N goes to DONE (or CSUM with the macro), else back to DATA.
  - CSUM: see Configuration.
  - DONE / ERR: `start` moves to LEN and clears `done`/`err`.
- `start` is ignored in LEN/DATA/WRITE/CSUM.
- `byte_ready` = 1 in LEN, DATA and CSUM; 0 in all other states.
- `mem_we` = 1 only in WRITE.
  - `mem_addr` = BASE_ADDR + 4*index.
  - `mem_wdata` holds the assembled word.
- `cpu_hold` = `busy` = 1 in LEN/DATA/WRITE/CSUM.
- Word index counter is ADDR_W+1 bits wide; addresses never wrap because N ≤ 2^ADDR_W is enforced.
- No handshake timeout; a stalled source leaves the loader waiting indefinitely.

## Timing

- Reset (`rst_n`=0 at a rising edge):
  - state goes to IDLE.
  - All outputs are 0: `byte_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_hold`, `busy`, `done`, `err`.
  - Index, count and checksum registers are 0.
- Reset mid-load aborts immediately. Words already written stay in memory; there is no rollback.
- The cycle after the `start` pulse: state = LEN, `byte_ready` = `busy` = `cpu_hold` = 1.
- The 4th byte of a word is accepted at edge k; `mem_we` is high during cycle k+1; DATA resumes at k+2.
- Per-word cost is therefore 5 cycles minimum, and the source sees one bubble per word.
- `cpu_hold` falls in the same cycle `done` or `err` rises.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last WRITE (or after LEN when N=0), enter CSUM and accept one byte.
  - That byte must equal the XOR of all 4N data bytes (0x00 when N=0).
  - Match goes to DONE, mismatch goes to ERR.
- Undefined:
  - The CSUM state and the XOR register do not exist.
  - The last WRITE goes straight to DONE; the stream carries no trailer byte.

## Test plan

- Reset, pulse `start`, send N=2 (02 00) then bytes 13 00 00 00 93 00 10 00 with `byte_valid` held high:
  - `mem_we` pulses twice: addr 0x0 with 0x00000013, then 0x4 with 0x00100093.
  - `done`=1 and `cpu_hold`=0 afterwards.
- `BASE_ADDR`=0x100, N=1, bytes AA BB CC DD, source inserts random `byte_valid` gaps:
  - single write of 0xDDCCBBAA at 0x100.
  - no `mem_we` while bytes are still missing.
- N=257 (01 01) with `ADDR_W`=8:
  - `err`=1 right after the second header byte.
  - no `mem_we`; `byte_ready`=0.
  - a new `start` clears `err`.
- Assert `rst_n`=0 after 5 data bytes of an N=2 load:
  - next cycle all outputs are 0 and state is IDLE.
  - exactly one write (word 0) occurred.
- With `IMEM_LOADER_CHECKSUM_EN`, N=1, bytes 01 02 04 08:
  - trailer 0x0F gives `done`=1.
  - repeat with trailer 0x0E gives `err`=1.
- Pulse `start` during DATA: no effect on state, index or address sequence.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: length header + little-endian words -> instruction memory writes.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [7:0]        hdr_lo;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   index;
    logic [ADDR_W:0]   index_nxt;
    logic [15:0]       hdr_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign index_nxt = index + 1'b1;
    assign hdr_n     = {byte_data, hdr_lo};

    // Outputs other than the data/flag registers decode the state register only.
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        mem_we     = (state == S_WRITE);
        case (state)
            S_LEN, S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            S_WRITE: busy = 1'b1;
            default: ;
        endcase
        cpu_hold = busy;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            hdr_lo    <= '0;
            count     <= '0;
            index     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN;
                        byte_cnt <= '0;
                        count    <= '0;
                        index    <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (byte_valid) begin
                        if (byte_cnt == 2'd0) begin
                            hdr_lo   <= byte_data;
                            byte_cnt <= 2'd1;
                        end else begin
                            byte_cnt <= '0;
                            count    <= hdr_n[ADDR_W:0];
                            if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_DONE;
                                done  <= 1'b1;
`endif
                            end else if ({1'b0, hdr_n} > MAX_WORDS) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (byte_valid) begin
                        // Shift in from the top so the first byte lands in [7:0].
                        mem_wdata <= {byte_data, mem_wdata[31:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum      <= csum ^ byte_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            state    <= S_WRITE;
                            mem_addr <= BASE_ADDR + {{(29 - ADDR_W){1'b0}}, index, 2'b00};
                        end
                    end
                end
                S_WRITE: begin
                    index <= index_nxt;
                    if (index_nxt == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state <= S_DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (byte_valid) begin
                        if (byte_data == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; two instances differ only in BASE_ADDR.
// Define IMEM_LOADER_CHECKSUM_EN to exercise the trailer checksum.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready, mem_we, cpu_hold, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic        byte_ready1, mem_we1, cpu_hold1, busy1, done1, err1;
    logic [31:0] mem_addr1, mem_wdata1;

    int errors = 0;
    int checks = 0;

    logic [31:0] wa0 [16];
    logic [31:0] wd0 [16];
    logic [31:0] wa1 [16];
    int          wr_cnt = 0;
    int          base;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    // Write strobes are a full cycle wide, so the falling edge sees them cleanly.
    always @(negedge clk) begin
        if (mem_we && wr_cnt < 16) begin
            wa0[wr_cnt] = mem_addr;
            wd0[wr_cnt] = mem_wdata;
            wa1[wr_cnt] = mem_addr1;
            wr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) step();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) step();
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
        chk("rst_mem_addr",   mem_addr,            32'd0);
        chk("rst_mem_wdata",  mem_wdata,           32'd0);
        chk("rst_cpu_hold",   {31'd0, cpu_hold},   32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_err",        {31'd0, err},        32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", {31'd0, byte_ready}, 32'd0);

        // Two-word load with the source always valid.
        pulse_start();
        chk("len_ready",    {31'd0, byte_ready}, 32'd1);
        chk("len_busy",     {31'd0, busy},       32'd1);
        chk("len_cpu_hold", {31'd0, cpu_hold},   32'd1);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("w0_we_cycle", {31'd0, mem_we}, 32'd1);
        chk("w0_ready_bubble", {31'd0, byte_ready}, 32'd0);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        chk("w1_we_cycle", {31'd0, mem_we},    32'd1);
        chk("w1_addr",     mem_addr,           32'h0000_0004);
        chk("w1_wdata",    mem_wdata,          32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h90, 0);
`else
        step();
`endif
        byte_valid = 1'b0;
        chk("t1_done",     {31'd0, done},     32'd1);
        chk("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t1_err",      {31'd0, err},      32'd0);
        chk("t1_wr_cnt",   wr_cnt,            32'd2);
        chk("t1_a0",       wa0[0],            32'h0000_0000);
        chk("t1_d0",       wd0[0],            32'h0000_0013);
        chk("t1_a1",       wa0[1],            32'h0000_0004);
        chk("t1_d1",       wd0[1],            32'h0010_0093);

        // One word with gaps on the source; checked against the BASE_ADDR=0x100 instance.
        base = wr_cnt;
        pulse_start();
        chk("t2_done_cleared", {31'd0, done1}, 32'd0);
        send_byte(8'h01, 2); send_byte(8'h00, 1);
        send_byte(8'hAA, 1); send_byte(8'hBB, 3); send_byte(8'hCC, 2);
        byte_valid = 1'b0;
        step(); step();
        chk("t2_no_early_write", wr_cnt - base, 32'd0);
        chk("t2_no_early_we",    {31'd0, mem_we1}, 32'd0);
        send_byte(8'hDD, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`else
        step();
`endif
        byte_valid = 1'b0;
        step();
        chk("t2_wr_cnt", wr_cnt - base, 32'd1);
        chk("t2_addr",   wa1[base],     32'h0000_0100);
        chk("t2_wdata",  wd0[base],     32'hDDCC_BBAA);
        chk("t2_done",   {31'd0, done1}, 32'd1);

        // Oversized header: N = 257.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        chk("t3_err",      {31'd0, err},        32'd1);
        chk("t3_ready",    {31'd0, byte_ready}, 32'd0);
        chk("t3_cpu_hold", {31'd0, cpu_hold},   32'd0);
        chk("t3_done",     {31'd0, done},       32'd0);
        step();
        byte_valid = 1'b0;
        chk("t3_no_write", wr_cnt - base,       32'd0);
        pulse_start();
        chk("t3_err_clear", {31'd0, err},  32'd0);
        chk("t3_busy",      {31'd0, busy}, 32'd1);

        // Reset part-way through the second word of an N=2 load.
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        base = wr_cnt;
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("t4_ready",    {31'd0, byte_ready}, 32'd0);
        chk("t4_we",       {31'd0, mem_we},     32'd0);
        chk("t4_addr",     mem_addr,            32'd0);
        chk("t4_wdata",    mem_wdata,           32'd0);
        chk("t4_busy",     {31'd0, busy},       32'd0);
        chk("t4_cpu_hold", {31'd0, cpu_hold},   32'd0);
        chk("t4_done",     {31'd0, done},       32'd0);
        chk("t4_err",      {31'd0, err},        32'd0);
        rst_n = 1'b1;
        step();
        chk("t4_idle_ready", {31'd0, byte_ready}, 32'd0);
        chk("t4_one_write",  wr_cnt - base,       32'd1);
        chk("t4_word0",      wd0[base],           32'h0000_0013);

        // Empty program.
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        byte_valid = 1'b0;
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // Start pulse during DATA must not disturb the load.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        byte_valid = 1'b0;
        pulse_start();
        chk("t6_still_ready", {31'd0, byte_ready}, 32'd1);
        chk("t6_still_busy",  {31'd0, busy},       32'd1);
        send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h88, 0);
`else
        step();
`endif
        byte_valid = 1'b0;
        step();
        chk("t6_wr_cnt", wr_cnt - base, 32'd2);
        chk("t6_a0",     wa0[base],     32'h0000_0000);
        chk("t6_d0",     wd0[base],     32'h4433_2211);
        chk("t6_a1",     wa0[base + 1], 32'h0000_0004);
        chk("t6_d1",     wd0[base + 1], 32'h8877_6655);
        chk("t6_done",   {31'd0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailer must equal the XOR of all data bytes: 01^02^04^08 = 0F.
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
        send_byte(8'h0F, 0);
        byte_valid = 1'b0;
        chk("cs_good_done", {31'd0, done}, 32'd1);
        chk("cs_good_err",  {31'd0, err},  32'd0);
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
        send_byte(8'h0E, 0);
        byte_valid = 1'b0;
        chk("cs_bad_err",  {31'd0, err},  32'd1);
        chk("cs_bad_done", {31'd0, done}, 32'd0);
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
